// File: rtl/d_sramlike_axi_bridge.sv
// d_sramlike_axi_bridge: SRAM-like cache port (req/addr_ok/data_ok) to single-beat AXI3 ar/r/aw/w/b bridge, one transaction outstanding
module d_sramlike_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] axi_rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RADDR = 3'd1;
  localparam logic [2:0] RDATA = 3'd2;
  localparam logic [2:0] WADDR = 3'd3;
  localparam logic [2:0] WRESP = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d, strb;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        aw_hs, w_hs;
  always_comb begin
    strb = size == 2'd0 ? 4'b0001 << addr[1:0] : size == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    aw_hs = awvalid & awready;
    w_hs = wvalid & wready;
    state_d = state_q;
    addr_d = addr_q;
    size_d = size_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d = addr;
        size_d = size == 2'd3 ? 2'd2 : size;
        wdata_d = wdata;
        wstrb_d = strb;
        state_d = wr ? WADDR : RADDR;
      end
      RADDR: if (arready) state_d = RDATA;
      RDATA: if (rvalid) state_d = IDLE;
      WADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d = w_done_q | w_hs;
        if (aw_done_d & w_done_d) begin
          state_d = WRESP;
          aw_done_d = 1'b0;
          w_done_d = 1'b0;
        end
      end
      WRESP: if (bvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      size_q <= size_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end
  assign addr_ok = state_q == IDLE && req;
  assign data_ok = (state_q == RDATA && rvalid) || (state_q == WRESP && bvalid);
  assign rdata = axi_rdata;
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awsize = {1'b0, size_q};
  assign axi_wdata = wdata_q;
  assign wstrb = wstrb_q;
  assign arvalid = state_q == RADDR;
  assign rready = state_q == RDATA;
  assign awvalid = state_q == WADDR && !aw_done_q;
  assign wvalid = state_q == WADDR && !w_done_q;
  assign bready = state_q == WRESP;
endmodule
